// File: rtl/selftrigger_readout_arbiter.sv
// Round-robin readout arbiter for NCH self-trigger channels: captures a timestamp per
// accepted trigger, serialises records over valid/ready, applies per-channel hold-off.
module selftrigger_readout_arbiter #(
    parameter int NCH  = 8,
    parameter int CH_W = $clog2(NCH),
    parameter int TS_W = 64,
    parameter int HO_W = 12,
    parameter int DC_W = 16
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            enable_i,
    input  logic [NCH-1:0]  ch_mask_i,
    input  logic [HO_W-1:0] holdoff_i,
    input  logic [TS_W-1:0] timestamp_i,
    input  logic [NCH-1:0]  trig_i,
    output logic            rec_valid_o,
    input  logic            rec_ready_i,
    output logic [CH_W-1:0] rec_channel_o,
    output logic [TS_W-1:0] rec_timestamp_o,
    output logic [NCH-1:0]  busy_o,
    output logic [DC_W-1:0] drop_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_HOLDOFF = 2'd2
    } ch_state_e;

    ch_state_e       state_q [NCH];
    logic [TS_W-1:0] ts_q    [NCH];
    logic [HO_W-1:0] cnt_q   [NCH];
    logic [CH_W-1:0] last_grant_q;
    logic            rec_valid_q;
    logic [CH_W-1:0] rec_channel_q;
    logic [TS_W-1:0] rec_ts_q;
    logic [DC_W-1:0] drop_q;

    logic [NCH-1:0]  pending;
    logic [NCH-1:0]  accept_vec;
    logic [NCH-1:0]  drop_vec;
    logic            gnt_valid_d;
    logic [CH_W-1:0] gnt_idx_d;
    logic            slot_free;
    logic [DC_W:0]   n_drops;
    logic [DC_W:0]   drop_sum;
    logic [DC_W-1:0] drop_d;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            pending[i]    = (state_q[i] == ST_PENDING);
            busy_o[i]     = (state_q[i] != ST_IDLE);
            accept_vec[i] = trig_i[i] & ch_mask_i[i] & enable_i & (state_q[i] == ST_IDLE);
            drop_vec[i]   = trig_i[i] & ch_mask_i[i] & enable_i & (state_q[i] != ST_IDLE);
        end
    end

    // Search starts one past the last grant and wraps, so channel last_grant is checked last.
    always_comb begin
        gnt_valid_d = 1'b0;
        gnt_idx_d   = '0;
        for (int k = 1; k <= NCH; k++) begin
            if (!gnt_valid_d && pending[(int'(last_grant_q) + k) % NCH]) begin
                gnt_valid_d = 1'b1;
                gnt_idx_d   = CH_W'((int'(last_grant_q) + k) % NCH);
            end
        end
    end

    assign slot_free = !rec_valid_q || rec_ready_i;

    always_comb begin
        n_drops = '0;
        for (int i = 0; i < NCH; i++) begin
            n_drops = n_drops + (DC_W+1)'(drop_vec[i]);
        end
        drop_sum = {1'b0, drop_q} + n_drops;
        drop_d   = drop_sum[DC_W] ? '1 : drop_sum[DC_W-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= ST_IDLE;
                ts_q[i]    <= '0;
                cnt_q[i]   <= '0;
            end
            last_grant_q  <= CH_W'(NCH - 1);
            rec_valid_q   <= 1'b0;
            rec_channel_q <= '0;
            rec_ts_q      <= '0;
            drop_q        <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (accept_vec[i]) begin
                            state_q[i] <= ST_PENDING;
                            ts_q[i]    <= timestamp_i;
                        end
                    end
                    ST_PENDING: begin
                        if (slot_free && gnt_valid_d && (gnt_idx_d == CH_W'(i))) begin
                            state_q[i] <= ST_HOLDOFF;
                            cnt_q[i]   <= holdoff_i;
                        end
                    end
                    ST_HOLDOFF: begin
                        if (cnt_q[i] == '0) begin
                            state_q[i] <= ST_IDLE;
                        end else begin
                            cnt_q[i] <= cnt_q[i] - 1'b1;
                        end
                    end
                    default: state_q[i] <= ST_IDLE;
                endcase
            end

            if (slot_free) begin
                if (gnt_valid_d) begin
                    rec_valid_q   <= 1'b1;
                    rec_channel_q <= gnt_idx_d;
                    rec_ts_q      <= ts_q[gnt_idx_d];
                    last_grant_q  <= gnt_idx_d;
                end else begin
                    rec_valid_q <= 1'b0;
                end
            end

            drop_q <= drop_d;
        end
    end

    assign rec_valid_o     = rec_valid_q;
    assign rec_channel_o   = rec_channel_q;
    assign rec_timestamp_o = rec_ts_q;
    assign drop_count_o    = drop_q;

endmodule

// File: tb/tb_selftrigger_readout_arbiter.sv
// Directed bench for selftrigger_readout_arbiter: latency, round-robin, backpressure,
// hold-off boundary, drops/saturation, masking, async reset.
module tb_selftrigger_readout_arbiter;

    localparam int NCH  = 8;
    localparam int CH_W = 3;
    localparam int TS_W = 64;
    localparam int HO_W = 12;
    localparam int DC_W = 16;

    logic            clk_i = 1'b0;
    logic            rst_n_i;
    logic            enable_i;
    logic [NCH-1:0]  ch_mask_i;
    logic [HO_W-1:0] holdoff_i;
    logic [TS_W-1:0] timestamp_i;
    logic [NCH-1:0]  trig_i;
    logic            rec_valid_o;
    logic            rec_ready_i;
    logic [CH_W-1:0] rec_channel_o;
    logic [TS_W-1:0] rec_timestamp_o;
    logic [NCH-1:0]  busy_o;
    logic [DC_W-1:0] drop_count_o;

    int n_checks = 0;
    int n_fail   = 0;

    selftrigger_readout_arbiter #(
        .NCH(NCH), .CH_W(CH_W), .TS_W(TS_W), .HO_W(HO_W), .DC_W(DC_W)
    ) dut (
        .clk_i(clk_i),
        .rst_n_i(rst_n_i),
        .enable_i(enable_i),
        .ch_mask_i(ch_mask_i),
        .holdoff_i(holdoff_i),
        .timestamp_i(timestamp_i),
        .trig_i(trig_i),
        .rec_valid_o(rec_valid_o),
        .rec_ready_i(rec_ready_i),
        .rec_channel_o(rec_channel_o),
        .rec_timestamp_o(rec_timestamp_o),
        .busy_o(busy_o),
        .drop_count_o(drop_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
        tick();
    endtask

    task automatic check_rec(input string tag, input int ch, input logic [63:0] ts);
        check({tag, "_valid"}, 64'(rec_valid_o), 64'd1);
        check({tag, "_ch"}, 64'(rec_channel_o), 64'(ch));
        check({tag, "_ts"}, rec_timestamp_o, ts);
    endtask

    initial begin
        int guard;
        rst_n_i     = 1'b0;
        enable_i    = 1'b1;
        ch_mask_i   = 8'hFF;
        holdoff_i   = 12'd4;
        timestamp_i = '0;
        trig_i      = '0;
        rec_ready_i = 1'b1;

        #12;
        check("rst_valid", 64'(rec_valid_o), 64'd0);
        check("rst_ch", 64'(rec_channel_o), 64'd0);
        check("rst_ts", rec_timestamp_o, 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_drop", 64'(drop_count_o), 64'd0);
        rst_n_i = 1'b1;
        tick();

        // Single trigger on ch3, holdoff=4, plus hold-off boundary
        trig_i = 8'h08; timestamp_i = 64'h100;
        tick();                                   // t+1
        trig_i = 8'h00; timestamp_i = 64'h200;
        check("s1_busy_t1", 64'(busy_o), 64'h08);
        check("s1_valid_t1", 64'(rec_valid_o), 64'd0);
        tick();                                   // t+2
        check_rec("s1_rec", 3, 64'h100);
        tick();                                   // t+3
        check("s1_valid_t3", 64'(rec_valid_o), 64'd0);
        check("s1_busy_t3", 64'(busy_o[3]), 64'd1);
        wait_cycles(3);                           // t+6, counter at zero
        check("s1_busy_t6", 64'(busy_o[3]), 64'd1);
        trig_i = 8'h08; timestamp_i = 64'h300;
        tick();                                   // t+7
        check("s1_busy_t7", 64'(busy_o[3]), 64'd0);
        check("s1_drop_ho0", 64'(drop_count_o), 64'd1);
        trig_i = 8'h08; timestamp_i = 64'h400;
        tick();                                   // t+8
        trig_i = 8'h00;
        check("s1_reacc_busy", 64'(busy_o[3]), 64'd1);
        tick();                                   // t+9
        check_rec("s1_rec2", 3, 64'h400);
        wait_cycles(10);

        // Round robin after reset: 0,2,5 then 0,2
        do_reset();
        trig_i = 8'h25; timestamp_i = 64'h111;
        tick();
        trig_i = 8'h00;
        tick();
        check_rec("rr_a", 0, 64'h111);
        tick();
        check_rec("rr_b", 2, 64'h111);
        tick();
        check_rec("rr_c", 5, 64'h111);
        tick();
        check("rr_idle", 64'(rec_valid_o), 64'd0);
        wait_cycles(8);
        trig_i = 8'h05; timestamp_i = 64'h222;
        tick();
        trig_i = 8'h00;
        tick();
        check_rec("rr_d", 0, 64'h222);
        tick();
        check_rec("rr_e", 2, 64'h222);
        wait_cycles(8);

        // Backpressure: last_grant=2, pending 1,3,6 -> 3,6,1
        rec_ready_i = 1'b0;
        trig_i = 8'h4A; timestamp_i = 64'h500;
        tick();
        trig_i = 8'h00; timestamp_i = 64'h501;
        tick();
        for (int k = 0; k < 10; k++) begin
            check_rec("bp_hold", 3, 64'h500);
            if (k < 9) tick();
        end
        rec_ready_i = 1'b1;
        tick();
        check_rec("bp_b", 6, 64'h500);
        tick();
        check_rec("bp_c", 1, 64'h500);
        tick();
        check("bp_idle", 64'(rec_valid_o), 64'd0);
        wait_cycles(8);

        // Drops with holdoff=20: trig[1] at t, t+3, t+10
        holdoff_i = 12'd20;
        for (int k = 0; k <= 10; k++) begin
            trig_i = (k == 0 || k == 3 || k == 10) ? 8'h02 : 8'h00;
            tick();
        end
        trig_i = 8'h00;
        check("drop_two", 64'(drop_count_o), 64'd2);
        wait_cycles(25);

        // Mask: trig[4] masked is ignored
        ch_mask_i = 8'hEF;
        trig_i = 8'h10;
        tick();
        trig_i = 8'h00;
        ch_mask_i = 8'hFF;
        wait_cycles(2);
        check("mask_valid", 64'(rec_valid_o), 64'd0);
        check("mask_busy", 64'(busy_o), 64'd0);
        check("mask_drop", 64'(drop_count_o), 64'd2);

        // Enable falls with ch0 pending: last_grant=1 so ch7 goes first
        holdoff_i = 12'd4;
        rec_ready_i = 1'b0;
        trig_i = 8'h81; timestamp_i = 64'h600;
        tick();
        enable_i = 1'b0;
        trig_i = 8'h01; timestamp_i = 64'h601;
        wait_cycles(3);
        check_rec("en_first", 7, 64'h600);
        check("en_busy", 64'(busy_o), 64'h81);
        check("en_nodrop", 64'(drop_count_o), 64'd2);
        rec_ready_i = 1'b1;
        tick();
        trig_i = 8'h00;
        check_rec("en_drain", 0, 64'h600);
        enable_i = 1'b1;
        tick();
        check("en_idle", 64'(rec_valid_o), 64'd0);
        wait_cycles(8);

        // Async reset while a record is held
        rec_ready_i = 1'b0;
        trig_i = 8'h04; timestamp_i = 64'h700;
        tick();
        trig_i = 8'h00;
        tick();
        check_rec("ar_pre", 2, 64'h700);
        #2 rst_n_i = 1'b0;
        #1;
        check("ar_valid", 64'(rec_valid_o), 64'd0);
        check("ar_ch", 64'(rec_channel_o), 64'd0);
        check("ar_ts", rec_timestamp_o, 64'd0);
        check("ar_busy", 64'(busy_o), 64'd0);
        check("ar_drop", 64'(drop_count_o), 64'd0);
        #1 rst_n_i = 1'b1;
        tick();
        rec_ready_i = 1'b1;
        trig_i = 8'h09; timestamp_i = 64'h800;
        tick();
        trig_i = 8'h00;
        tick();
        check_rec("ar_first", 0, 64'h800);
        tick();
        check_rec("ar_second", 3, 64'h800);
        wait_cycles(8);

        // Saturation: all channels busy with long hold-off, trigger every cycle
        do_reset();
        holdoff_i = 12'd4095;
        trig_i = 8'hFF;
        guard = 0;
        while (drop_count_o != 16'hFFFF && guard < 12000) begin
            tick();
            guard++;
        end
        check("sat_reach", 64'(drop_count_o), 64'hFFFF);
        wait_cycles(5);
        check("sat_hold", 64'(drop_count_o), 64'hFFFF);
        trig_i = 8'h00;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/selftrigger_readout_arbiter.md
# selftrigger_readout_arbiter

Shares one record-builder input among NCH self-trigger channels, each channel being the trigger output of one filter/trigger pipeline. Captures a timestamp per accepted trigger, holds it until granted, and serialises records through a valid/ready port using round-robin arbitration. Enforces a programmable per-channel hold-off and counts triggers that arrive while a channel is busy.

## Interface
- NCH, 8: number of trigger channels (2..16).
- CH_W, $clog2(NCH): channel index width.
- TS_W, 64: timestamp width.
- HO_W, 12: hold-off counter width.
- DC_W, 16: drop counter width.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- enable  in  1  global trigger acceptance enable.
- ch_mask  in  NCH  per-channel acceptance mask; 1 = channel enabled.
- holdoff  in  HO_W  hold-off length in cycles; sampled only at grant.
- timestamp  in  TS_W  free-running timestamp.
- trig  in  NCH  per-channel trigger pulse, one bit per channel.
- rec_valid  out  1  record available.
- rec_ready  in  1  consumer accepts record when high with rec_valid.
- rec_channel  out  CH_W  channel of the presented record.
- rec_timestamp  out  TS_W  timestamp captured at trigger cycle.
- busy  out  NCH  1 while channel is PENDING or HOLDOFF.
- drop_count  out  DC_W  saturating count of dropped triggers.

## Operation
- Per-channel FSM with states IDLE, PENDING, HOLDOFF, a TS_W timestamp register, and an HO_W down-counter.
- IDLE -> PENDING: trig[i]=1, ch_mask[i]=1, enable=1. ts_reg[i] <= timestamp of that cycle.
- trig[i]=1 with ch_mask[i]=0 or enable=0: ignored, not counted.
- trig[i]=1 with ch_mask[i]=1, enable=1, and state PENDING or HOLDOFF: dropped. ts_reg[i] is unchanged. The trigger counts as one drop.
- drop_count adds the number of channels dropping in that cycle (0..NCH) and saturates at all-ones.
- Output slot is free when rec_valid=0 or (rec_valid & rec_ready).
- When the slot is free and any channel is PENDING, grant the first PENDING channel found searching last_grant+1, last_grant+2, ... with wrap. On grant:
  - rec_valid <= 1.
  - rec_channel <= i.
  - rec_timestamp <= ts_reg[i].
  - last_grant <= i.
  - State[i] PENDING -> HOLDOFF, counter[i] <= holdoff.
- When the slot is free and no channel is PENDING, rec_valid <= 0.
- Only one grant per cycle.
- HOLDOFF: counter decrements each cycle. When counter=0, state -> IDLE at the next edge. A trigger in the cycle where counter=0 is still dropped.
- PENDING channels are drained when enable or ch_mask is deasserted. Masking never cancels a pending record.
- Changing holdoff mid-count does not affect running counters.

## Timing
- Reset values:
  - rec_valid=0, rec_channel=0, rec_timestamp=0.
  - busy=0, drop_count=0.
  - All FSMs IDLE, counters 0.
  - last_grant=NCH-1, so channel 0 has first priority.
- Reset asserted mid-operation clears everything immediately, including a presented but unaccepted record.
- Latency with a free slot: trig in cycle t -> PENDING and busy visible in t+1 -> rec_valid=1 in t+2.
- Back-to-back: with rec_ready held high, one record per cycle from consecutive grants.
- Valid/ready rules:
  - rec_channel and rec_timestamp are stable while rec_valid=1 and rec_ready=0.
  - rec_valid never drops without a handshake.
  - rec_ready is ignored when rec_valid=0.
- Hold-off: grant at cycle g -> channel re-accepts a trigger at the earliest in cycle g+holdoff+2. With holdoff=0, HOLDOFF lasts one cycle.
- No combinational path from rec_ready to rec_valid except through the slot-free term. All outputs are registered except busy, which is decoded from registered state.

## Test plan
- Single trigger: NCH=8, holdoff=4, trig[3] pulse at t with timestamp=0x100.
  - rec_valid at t+2, rec_channel=3, rec_timestamp=0x100.
  - busy[3] is high from t+1 until t+7.
- Round-robin: trig[0], trig[2], trig[5] in the same cycle, rec_ready=1.
  - Records appear on three consecutive cycles as 0, 2, 5.
  - Next simultaneous trig[0] and trig[2] grants 0 then 2, because last_grant=5 wraps.
- Backpressure: rec_ready=0 for 10 cycles with 3 channels pending.
  - The first record is held stable for all 10 cycles.
  - After rec_ready=1, the remaining two records follow on successive cycles.
- Drops and saturation, holdoff=20:
  - trig[1] at t, again at t+3 and t+10 -> drop_count=2.
  - Preload by 65535 drops, then one more drop -> drop_count stays 0xFFFF.
- Mask and enable:
  - trig[4] with ch_mask[4]=0 -> no record, drop_count unchanged.
  - A PENDING channel when enable falls -> its record is still delivered.
- Async reset mid-handshake: assert reset while rec_valid=1 and rec_ready=0.
  - All outputs are 0 immediately.
  - After release, trig[0] is served first.
